// File: rtl/mure_retire_scheduler_if.sv
// mure_retire_scheduler_if: shared retire types and the FIFO/encoder bundle of the retire scheduler
package mure_pkg;
    localparam int XLEN        = 32;
    localparam int ITYPE_LEN   = 4;
    localparam int INST_LEN    = 32;
    localparam int IRETIRE_LEN = 3;
    localparam int CAUSE_LEN   = 5;
    localparam int PRIV_LEN    = 2;
    localparam int NRET        = 2;

    typedef struct packed {
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } common_entry_s;

    typedef struct packed {
        logic [ITYPE_LEN-1:0]              itype;
        logic [XLEN-1:0]                   iaddr;
        logic [IRETIRE_LEN-1:0]            iretire;
        logic [$clog2(INST_LEN/16)-1:0]    ilastsize;
    } uop_entry_s;
endpackage

interface mure_retire_if #(
    parameter int CNT_W = 16
);
    import mure_pkg::*;
    logic                                 common_empty_i;
    common_entry_s                        common_entry_i;
    logic [NRET-1:0]                      common_lanes_i;
    logic                                 common_pop_o;
    logic [NRET-1:0]                      uop_empty_i;
    uop_entry_s                           uop_entry0_i;
    uop_entry_s                           uop_entry1_i;
    logic [NRET-1:0]                      uop_pop_o;
    logic                                 valid_o;
    logic                                 ready_i;
    logic [ITYPE_LEN-1:0]                 itype_o;
    logic [XLEN-1:0]                      iaddr_o;
    logic [IRETIRE_LEN-1:0]               iretire_o;
    logic [$clog2(INST_LEN/16)-1:0]       ilastsize_o;
    logic [CAUSE_LEN-1:0]                 cause_o;
    logic [XLEN-1:0]                      tval_o;
    logic [PRIV_LEN-1:0]                  priv_o;
    logic                                 empty_group_o;
    logic [CNT_W-1:0]                     beat_cnt_o;

    modport master (
        input  common_empty_i, common_entry_i, common_lanes_i, uop_empty_i,
               uop_entry0_i, uop_entry1_i, ready_i,
        output common_pop_o, uop_pop_o, valid_o, itype_o, iaddr_o, iretire_o,
               ilastsize_o, cause_o, tval_o, priv_o, empty_group_o, beat_cnt_o
    );

    modport slave (
        output common_empty_i, common_entry_i, common_lanes_i, uop_empty_i,
               uop_entry0_i, uop_entry1_i, ready_i,
        input  common_pop_o, uop_pop_o, valid_o, itype_o, iaddr_o, iretire_o,
               ilastsize_o, cause_o, tval_o, priv_o, empty_group_o, beat_cnt_o
    );
endinterface

// File: rtl/mure_retire_scheduler.sv
// mure_retire_scheduler: serialises each common retire group into one encoder beat per masked lane
module mure_retire_scheduler
    import mure_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic           clk_i,
    input logic           rst_i,
    mure_retire_if.master bus
);
    typedef enum logic [1:0] {IDLE, LANE0, LANE1} state_e;

    state_e          state_q, state_d;
    uop_entry_s      uop_q;
    common_entry_s   com_q;
    logic            valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic            lane, slot_free, load, drop, last;

    // group walk: pick the next lane, pop the lane head on load, pop the group on its last beat
    always_comb begin
        state_d = state_q;
        lane = state_q == LANE1;
        slot_free = !valid_q || bus.ready_i;
        load = !rst_i && state_q != IDLE && slot_free && !bus.uop_empty_i[lane];
        drop = !rst_i && state_q == IDLE && !bus.common_empty_i && bus.common_lanes_i == 2'b00;
        last = !(state_q == LANE0 && bus.common_lanes_i[1]);
        bus.uop_pop_o = load ? (lane ? 2'b10 : 2'b01) : 2'b00;
        bus.common_pop_o = drop || (load && last);
        bus.empty_group_o = drop;
        if (state_q == IDLE && !bus.common_empty_i)
            state_d = bus.common_lanes_i[0] ? LANE0 : bus.common_lanes_i[1] ? LANE1 : IDLE;
        else if (load)
            state_d = last ? IDLE : LANE1;
    end

    // state, output beat register (held until accepted) and accepted-beat counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            uop_q <= '0;
            com_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                uop_q <= lane ? bus.uop_entry1_i : bus.uop_entry0_i;
                com_q <= bus.common_entry_i;
                valid_q <= 1'b1;
            end else if (bus.ready_i) begin
                valid_q <= 1'b0;
            end
            if (valid_q && bus.ready_i)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.itype_o     = uop_q.itype;
    assign bus.iaddr_o     = uop_q.iaddr;
    assign bus.iretire_o   = uop_q.iretire;
    assign bus.ilastsize_o = uop_q.ilastsize;
    assign bus.cause_o     = com_q.cause;
    assign bus.tval_o      = com_q.tval;
    assign bus.priv_o      = com_q.priv;
    assign bus.beat_cnt_o  = cnt_q;
endmodule

// File: tb/tb_mure_retire_scheduler.sv
// tb_mure_retire_scheduler: directed scoreboard bench for the retire scheduler
module tb_mure_retire_scheduler;
    import mure_pkg::*;

    localparam int CW = 4;

    typedef struct packed {
        uop_entry_s    u;
        common_entry_s c;
    } beat_s;

    typedef struct packed {
        common_entry_s c;
        logic [1:0]    m;
    } grp_s;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mure_retire_if #(.CNT_W(CW)) bus ();
    mure_retire_scheduler #(.CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    uop_entry_s lq0[$];
    uop_entry_s lq1[$];
    grp_s       cq[$];
    beat_s      exp_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [1:0] lu;
    logic       lc, le;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic uop_entry_s mk_u(input logic [3:0] t, input logic [31:0] a, input logic [2:0] r, input logic s);
        uop_entry_s u;
        u.itype = t;
        u.iaddr = a;
        u.iretire = r;
        u.ilastsize = s;
        return u;
    endfunction

    function automatic common_entry_s mk_c(input logic [4:0] ca, input logic [31:0] tv, input logic [1:0] p);
        common_entry_s c;
        c.cause = ca;
        c.tval = tv;
        c.priv = p;
        return c;
    endfunction

    task automatic refresh();
        bus.uop_empty_i = {lq1.size() == 0, lq0.size() == 0};
        bus.uop_entry0_i = lq0.size() != 0 ? lq0[0] : '0;
        bus.uop_entry1_i = lq1.size() != 0 ? lq1[0] : '0;
        bus.common_empty_i = cq.size() == 0;
        bus.common_entry_i = cq.size() != 0 ? cq[0].c : '0;
        bus.common_lanes_i = cq.size() != 0 ? cq[0].m : 2'b00;
    endtask

    // one clock: present FIFO heads, latch the pops the DUT is about to act on, then retire them
    task automatic tick();
        logic bad;
        refresh();
        #1;
        lu = bus.uop_pop_o;
        lc = bus.common_pop_o;
        le = bus.empty_group_o;
        bad = (lu == 2'b11) || (lu[0] && lq0.size() == 0) || (lu[1] && lq1.size() == 0) || (lc && cq.size() == 0);
        check("pop_legal", {95'd0, bad}, 96'd0);
        @(posedge clk);
        @(negedge clk);
        if (lu[0] && lq0.size() != 0) void'(lq0.pop_front());
        if (lu[1] && lq1.size() != 0) void'(lq1.pop_front());
        if (lc && cq.size() != 0) void'(cq.pop_front());
    endtask

    task automatic group(input logic [1:0] m, input common_entry_s c, input uop_entry_s u0, input uop_entry_s u1);
        cq.push_back('{c, m});
        if (m[0]) begin
            lq0.push_back(u0);
            exp_q.push_back('{u0, c});
        end
        if (m[1]) begin
            lq1.push_back(u1);
            exp_q.push_back('{u1, c});
        end
    endtask

    function automatic beat_s cur_beat();
        beat_s b;
        b.u = mk_u(bus.itype_o, bus.iaddr_o, bus.iretire_o, bus.ilastsize_o);
        b.c = mk_c(bus.cause_o, bus.tval_o, bus.priv_o);
        return b;
    endfunction

    // monitor: every accepted beat must match the oldest expected beat
    initial begin
        beat_s e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", {16'd0, cur_beat()}, 96'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {16'd0, cur_beat()}, {16'd0, e});
                end
            end
        end
    end

    initial begin
        uop_entry_s a0, a1, b1, s0, c0, c1, d0, d1, w0;
        common_entry_s ca, cb, cc, cd, cw, cz;
        logic seen0;
        a0 = mk_u(4'h1, 32'h0000_1000, 3'd1, 1'b0);
        a1 = mk_u(4'h2, 32'h0000_1004, 3'd2, 1'b1);
        b1 = mk_u(4'h3, 32'h0000_2000, 3'd3, 1'b0);
        s0 = mk_u(4'h4, 32'h0000_3000, 3'd4, 1'b1);
        c0 = mk_u(4'h5, 32'h0000_4000, 3'd5, 1'b0);
        c1 = mk_u(4'h6, 32'h0000_4002, 3'd6, 1'b1);
        d0 = mk_u(4'h7, 32'h0000_5000, 3'd7, 1'b0);
        d1 = mk_u(4'h8, 32'h0000_5004, 3'd1, 1'b1);
        w0 = mk_u(4'h9, 32'h0000_6000, 3'd2, 1'b0);
        ca = mk_c(5'd2, 32'hDEAD_0001, 2'd3);
        cb = mk_c(5'd7, 32'hBEEF_0002, 2'd1);
        cc = mk_c(5'd11, 32'hCAFE_0003, 2'd0);
        cd = mk_c(5'd13, 32'hF00D_0004, 2'd2);
        cw = mk_c(5'd1, 32'h1234_5678, 2'd3);
        cz = mk_c(5'd31, 32'hFFFF_0000, 2'd1);
        bus.ready_i = 1'b1;
        refresh();
        @(negedge clk);
        group(2'b00, cz, a0, a0);
        tick();
        check("rst_common_pop", {95'd0, lc}, 96'd0);
        check("rst_empty_group", {95'd0, le}, 96'd0);
        tick();
        check("rst_uop_pop", {94'd0, lu}, 96'd0);
        check("rst_valid", {95'd0, bus.valid_o}, 96'd0);
        check("rst_cnt", {92'd0, bus.beat_cnt_o}, 96'd0);
        check("rst_fields", {16'd0, cur_beat()}, 96'd0);
        rst = 1'b0;
        tick();
        check("m00_empty_group", {95'd0, le}, 96'd1);
        check("m00_common_pop", {95'd0, lc}, 96'd1);
        check("m00_uop_pop", {94'd0, lu}, 96'd0);
        tick();
        check("m00_pulse_end", {95'd0, le}, 96'd0);
        check("m00_no_beat", {95'd0, bus.valid_o}, 96'd0);
        group(2'b11, ca, a0, a1);
        tick();
        check("m11_idle_pop", {93'd0, lu, lc}, 96'd0);
        tick();
        check("m11_l0_pop", {93'd0, lu, lc}, {93'd0, 2'b01, 1'b0});
        tick();
        check("m11_l1_pop", {93'd0, lu, lc}, {93'd0, 2'b10, 1'b1});
        tick();
        tick();
        check("m11_cnt", {92'd0, bus.beat_cnt_o}, 96'd2);
        check("m11_idle_valid", {95'd0, bus.valid_o}, 96'd0);
        lq0.push_back(s0);
        group(2'b10, cb, a0, b1);
        seen0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen0 = seen0 | lu[0];
        end
        check("m10_no_lane0_pop", {95'd0, seen0}, 96'd0);
        check("m10_lane0_depth", 96'(lq0.size()), 96'd1);
        check("m10_cnt", {92'd0, bus.beat_cnt_o}, 96'd3);
        cq.push_back('{cc, 2'b01});
        exp_q.push_back('{s0, cc});
        for (int i = 0; i < 3; i++) tick();
        check("m01_lane0_drained", 96'(lq0.size()), 96'd0);
        bus.ready_i = 1'b0;
        group(2'b11, cd, c0, c1);
        tick();
        tick();
        check("stall_l0_pop", {94'd0, lu}, {94'd0, 2'b01});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_no_pop", {93'd0, lu, lc}, 96'd0);
            check("stall_valid", {95'd0, bus.valid_o}, 96'd1);
            check("stall_fields", {16'd0, cur_beat()}, {16'd0, c0, cd});
        end
        bus.ready_i = 1'b1;
        tick();
        check("accept_l1_pop", {93'd0, lu, lc}, {93'd0, 2'b10, 1'b1});
        check("accept_l1_fields", {16'd0, cur_beat()}, {16'd0, c1, cd});
        tick();
        tick();
        check("stall_cnt", {92'd0, bus.beat_cnt_o}, 96'd6);
        bus.ready_i = 1'b0;
        group(2'b11, ca, d0, d1);
        tick();
        tick();
        check("pre_rst_valid", {95'd0, bus.valid_o}, 96'd1);
        check("pre_rst_state", {94'd0, dut.state_q}, 96'd2);
        rst = 1'b1;
        tick();
        check("rst_mid_pops", {93'd0, lu, lc}, 96'd0);
        check("rst_mid_valid", {95'd0, bus.valid_o}, 96'd0);
        check("rst_mid_state", {94'd0, dut.state_q}, 96'd0);
        lq0.delete();
        lq1.delete();
        cq.delete();
        exp_q.delete();
        rst = 1'b0;
        bus.ready_i = 1'b1;
        tick();
        check("rst_mid_cnt", {92'd0, bus.beat_cnt_o}, 96'd0);
        check("rst_mid_idle_pops", {93'd0, lu, lc}, 96'd0);
        for (int i = 0; i < 15; i++) group(2'b01, cw, w0, w0);
        for (int i = 0; i < 34; i++) tick();
        check("cnt_max", {92'd0, bus.beat_cnt_o}, 96'd15);
        group(2'b01, cw, w0, w0);
        for (int i = 0; i < 4; i++) tick();
        check("cnt_wrap", {92'd0, bus.beat_cnt_o}, 96'd0);
        check("scoreboard_drained", 96'(exp_q.size()), 96'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mure_retire_scheduler.md
MURE_RETIRE_SCHEDULER -- requirements
Module: mure_retire_scheduler

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, width of the emitted-beat counter.
REQ-002 The block SHALL use the package constants XLEN, ITYPE_LEN, INST_LEN, IRETIRE_LEN, CAUSE_LEN and PRIV_LEN, and the struct types common_entry_s and uop_entry_s, with NRET fixed at 2.
REQ-003 The block SHALL have the following ports:
- clk_i  in  1  clock; one clock domain; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- common_empty_i  in  1  common FIFO is empty.
- common_entry_i  in  common_entry_s  common FIFO head (cause, tval, priv).
- common_lanes_i  in  2  lane mask of the head group; bit n set means lane n holds a uop.
- common_pop_o  out  1  pops the common FIFO head.
- uop_empty_i  in  2  per-lane uop FIFO is empty.
- uop_entry0_i, uop_entry1_i  in  uop_entry_s  per-lane uop FIFO heads.
- uop_pop_o  out  2  per-lane uop FIFO pops.
- valid_o  out  1  encoder beat is valid.
- ready_i  in  1  encoder accepts the beat.
- itype_o, iaddr_o, iretire_o, ilastsize_o  out  per uop_entry_s  beat uop fields.
- cause_o, tval_o, priv_o  out  per common_entry_s  beat common fields.
- empty_group_o  out  1  one-cycle pulse when a group with mask 0 is dropped.
- beat_cnt_o  out  CNT_W  count of accepted beats.

Function
REQ-004 The FSM SHALL have three states, IDLE, LANE0 and LANE1, and SHALL serialise each common group into one beat per masked lane in ascending lane order.
REQ-005 In IDLE with !common_empty_i: if mask[0] the FSM SHALL go to LANE0; else if mask[1] it SHALL go to LANE1; else (mask 00) it SHALL assert common_pop_o and empty_group_o for one cycle and stay in IDLE.
REQ-006 In LANEn, the output slot is free when !valid_o || ready_i; if the slot is free and !uop_empty_i[n], the block SHALL load the output register from lane n's head and from common_entry_i, assert uop_pop_o[n], and set valid_o.
REQ-007 On that load, if the state is LANE0 and mask[1] is set, the FSM SHALL go to LANE1; otherwise the block SHALL assert common_pop_o in the same cycle and return to IDLE.
REQ-008 In LANEn, if lane n is empty or the output slot is not free, the block SHALL stall with no pops and no state change.
REQ-009 valid_o and all beat fields SHALL stay stable while valid_o && !ready_i.
REQ-010 When ready_i is high and no new load occurs, valid_o SHALL clear in the next cycle.
REQ-011 Latency SHALL be one cycle from pop to valid_o; a new beat can load in the same cycle an old beat is accepted.
REQ-012 uop_pop_o SHALL never assert for an empty lane, and common_pop_o SHALL never assert when common_empty_i is high.
REQ-013 At most one uop_pop_o bit SHALL be high per cycle.
REQ-014 beat_cnt_o SHALL increment on each valid_o && ready_i and SHALL wrap modulo 2^CNT_W.
REQ-015 cause_o and tval_o SHALL be copied on every beat regardless of itype.
REQ-016 Sustained throughput SHALL be 2 beats per 3 cycles for mask 11 and 1 beat per 2 cycles for single-lane groups.

Reset
REQ-017 While rst_i is high, the block SHALL set the FSM to IDLE, and drive valid_o, common_pop_o, uop_pop_o, empty_group_o and beat_cnt_o to 0 and all beat fields to 0.
REQ-018 A reset mid-group SHALL discard the pending beat and the group position without popping; FIFO flushing is the owner's responsibility.
REQ-019 After rst_i falls, the block SHALL issue no pop before the first IDLE evaluation.

Verification
REQ-020 Mask 11, both lanes pre-filled, ready_i=1: the bench SHALL see beats lane0 then lane1 on consecutive cycles, one common_pop_o coincident with uop_pop_o=10, and beat_cnt_o=2.
REQ-021 Mask 10 with lane0 non-empty: the bench SHALL see a single beat from lane1 only, uop_pop_o[0] never asserted, and lane0 untouched.
REQ-022 Mask 00: the bench SHALL see a one-cycle empty_group_o and common_pop_o pulse and no beat.
REQ-023 ready_i=0 for 5 cycles during a mask 11 group: valid_o SHALL stay high with fields stable, there SHALL be no lane1 pop until acceptance, and the lane1 beat SHALL follow in the acceptance cycle.
REQ-024 rst_i asserted in LANE1 with valid_o=1: in the next cycle valid_o=0, the FSM is in IDLE, and all pops are 0.
REQ-025 With beat_cnt_o at 2^CNT_W-1, one accepted beat SHALL wrap beat_cnt_o to 0.
